riscv_lsu: RTL
==============

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter NBYTES, default XLEN/8, number of byte lanes; derived, not overridden.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req_valid/req_ready  input/output  1/1  core request handshake.
REQ-006 SHALL have ports req_we  input  1, and req_size  input  3 (funct3: bit2 = unsigned, bits1:0 = log2 bytes).
REQ-007 SHALL have ports req_addr and req_wdata  input  XLEN  byte address and store data.
REQ-008 SHALL have ports resp_valid  output  1, resp_rdata  output  XLEN, and resp_err  output  1.
REQ-009 SHALL have port stall  output  1  high while an accepted access is incomplete.
REQ-010 SHALL have ports mem_req, mem_we  output  1, mem_be  output  NBYTES, mem_addr and mem_wdata  output  XLEN.
REQ-011 SHALL have ports mem_gnt, mem_rvalid  input  1, and mem_rdata  input  XLEN.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-013 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on req_valid&req_ready, latching we, size, addr and wdata.
REQ-014 IDLE->REQ on a legal accepted request; IDLE->DONE with resp_err=1 and no mem_req on an illegal one.
REQ-015 Illegal: size[1:0]=3 when XLEN=32; size[2]=1 with req_we=1; size[2]=1 with size[1:0]=3.
REQ-016 In REQ, mem_req SHALL be 1 with stable mem_addr/mem_we/mem_be/mem_wdata until mem_gnt; mem_gnt -> WAIT.
REQ-017 In WAIT, mem_rvalid SHALL move to DONE, capturing the aligned load data; mem_rvalid outside WAIT is ignored.
REQ-018 DONE SHALL last one cycle with resp_valid=1, then return to IDLE.
REQ-019 Minimum latency: accept cycle N, mem_req cycle N+1, mem_rvalid N+2, resp_valid N+3.
REQ-020 stall SHALL be 1 in REQ and WAIT and 0 in IDLE and DONE.
REQ-021 mem_addr SHALL be req_addr with the low log2(NBYTES) bits cleared.
REQ-022 mem_be SHALL be (2^size-1) shifted left by the byte offset; mem_wdata SHALL be wdata shifted left by 8*offset.
REQ-023 Load data SHALL be mem_rdata shifted right by 8*offset and then sign- or zero-extended per size[2].
REQ-024 resp_rdata SHALL be 0 for stores and for errored accesses.
REQ-025 req_valid during REQ/WAIT/DONE SHALL be ignored, and the request SHALL not be latched.

Reset
REQ-026 Reset SHALL force IDLE asynchronously at any state, including mid-access.
REQ-027 After reset, mem_req, resp_valid, resp_err and stall SHALL be 0, and resp_rdata, mem_be, mem_addr and mem_wdata SHALL be 0.
REQ-028 A memory response pending at reset SHALL be dropped and produce no resp_valid.

Configuration
REQ-029 Macro RISCV_LSU_MISALIGN_TRAP_EN: when defined, an address not a multiple of 2^size[1:0] SHALL be illegal (REQ-014 error path, no mem_req).
REQ-030 Without RISCV_LSU_MISALIGN_TRAP_EN, the offset bits below the access size SHALL be cleared (silent align-down) and the access SHALL proceed.

Structure
REQ-031 Package riscv_lsu_pkg SHALL hold the state enum, the size encodings (SZ_B/H/W/D, unsigned bit) and the legality function.
REQ-032 Sub-module riscv_lsu_align (combinational) SHALL compute mem_be, the shifted wdata and the extended load data.

Verification
REQ-033 XLEN=32, LB at 0x103, mem_rdata 0x80FF_FF00 -> mem_be 0x8, resp_rdata 0xFFFF_FF80, resp_valid at N+3.
REQ-034 SH 0x1234 at 0x202 -> mem_addr 0x200, mem_be 0xC, mem_wdata 0x1234_0000, resp_err 0.
REQ-035 mem_gnt delayed 3 cycles and mem_rvalid 2 more -> mem_req held stable 4 cycles, stall high throughout, single resp_valid.
REQ-036 LW at 0x101: with macro -> resp_err=1, no mem_req, resp at N+1; without macro -> mem_addr 0x100, mem_be 0xF.
REQ-037 Reset asserted in WAIT, then mem_rvalid -> no resp_valid, req_ready=1 after release, next LW completes normally.
REQ-038 XLEN=64, LD (size 3) at 0x8 -> mem_be 0xFF; same request at XLEN=32 -> resp_err=1.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared types for the RISC-V load/store unit: FSM states, funct3 size
// encodings and the access-legality rule.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    localparam int unsigned SZ_UNSIGNED_BIT = 2;

    // Doubleword needs a 64-bit datapath; unsigned only exists for loads narrower than D.
    function automatic logic access_legal(input logic we, input logic [2:0] size,
                                          input int unsigned xlen);
        logic uns;
        uns = size[SZ_UNSIGNED_BIT];
        return !((xlen == 32 && size[1:0] == SZ_D) || (uns && we) || (uns && size[1:0] == SZ_D));
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: store byte enables and data shift, load shift and
// sign/zero extension.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NBYTES = XLEN / 8,
    parameter int unsigned OFFW   = $clog2(XLEN / 8)
) (
    input  logic [1:0]        st_size,
    input  logic [OFFW-1:0]   st_off,
    input  logic [XLEN-1:0]   st_wdata,
    output logic [NBYTES-1:0] st_be,
    output logic [XLEN-1:0]   st_wdata_sh,
    input  logic [2:0]        ld_size,
    input  logic [OFFW-1:0]   ld_off,
    input  logic [XLEN-1:0]   ld_rdata,
    output logic [XLEN-1:0]   ld_data
);

    logic [NBYTES-1:0] mask;
    int unsigned       nbits;
    int unsigned       kshift;
    logic [XLEN-1:0]   shr;
    logic [XLEN-1:0]   shl;

    always_comb begin
        mask = NBYTES'(1);
        case (st_size)
            SZ_H:    mask = NBYTES'(2'b11);
            SZ_W:    mask = NBYTES'(4'hF);
            SZ_D:    mask = NBYTES'(8'hFF);
            default: ;
        endcase
        st_be       = mask << st_off;
        st_wdata_sh = st_wdata << {st_off, 3'b000};
    end

    // Move the field to the top, then shift back logically or arithmetically to extend.
    always_comb begin
        nbits   = 32'd8 << ld_size[1:0];
        kshift  = (nbits >= XLEN) ? 32'd0 : XLEN - nbits;
        shr     = ld_rdata >> {ld_off, 3'b000};
        shl     = shr << kshift;
        ld_data = ld_size[SZ_UNSIGNED_BIT] ? (shl >> kshift) : XLEN'($signed(shl) >>> kshift);
    end

endmodule

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: one outstanding access, single-request memory port.
// Optional macro RISCV_LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NBYTES = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [NBYTES-1:0] mem_be,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned OFFW = $clog2(NBYTES);

    lsu_state_e        state;
    logic              lat_we;
    logic [2:0]        lat_size;
    logic [OFFW-1:0]   lat_off;
    logic [OFFW-1:0]   off_raw;
    logic [OFFW-1:0]   sz_mask;
    logic [OFFW-1:0]   off_al;
    logic              legal;
    logic [NBYTES-1:0] st_be;
    logic [XLEN-1:0]   st_wdata_sh;
    logic [XLEN-1:0]   ld_data;

    // Offset is rounded down to the access size; under the trap macro a nonzero remainder is an error.
    always_comb begin
        off_raw = req_addr[OFFW-1:0];
        sz_mask = OFFW'((32'd1 << req_size[1:0]) - 32'd1);
        off_al  = off_raw & ~sz_mask;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        legal   = access_legal(req_we, req_size, XLEN) && ((off_raw & sz_mask) == '0);
`else
        legal   = access_legal(req_we, req_size, XLEN);
`endif
    end

    riscv_lsu_align #(.XLEN(XLEN), .NBYTES(NBYTES), .OFFW(OFFW)) u_align (
        .st_size     (req_size[1:0]),
        .st_off      (off_al),
        .st_wdata    (req_wdata),
        .st_be       (st_be),
        .st_wdata_sh (st_wdata_sh),
        .ld_size     (lat_size),
        .ld_off      (lat_off),
        .ld_rdata    (mem_rdata),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            stall      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            lat_we     <= 1'b0;
            lat_size   <= 3'd0;
            lat_off    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        lat_we    <= req_we;
                        lat_size  <= req_size;
                        lat_off   <= off_al;
                        if (legal) begin
                            state     <= S_REQ;
                            stall     <= 1'b1;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= st_be;
                            mem_addr  <= {req_addr[XLEN-1:OFFW], OFFW'(0)};
                            mem_wdata <= st_wdata_sh;
                        end else begin
                            state      <= S_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        state   <= S_WAIT;
                        mem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        state      <= S_DONE;
                        stall      <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= lat_we ? '0 : ld_data;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
